// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_queue
// Description : Sequential instruction fetch with a credit-limited prefetch
//               FIFO feeding decode. Branch redirects flush the FIFO and drop
//               responses that are still in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        CLOCK,
    input  logic        RESET,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc_plus4
);

    localparam int          c_PW    = $clog2(DEPTH);
    localparam int          c_CW    = c_PW + 1;
    localparam logic [c_CW:0] c_DEPTH = (c_CW + 1)'(DEPTH);

    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_head_pc;
    logic [31:0]     r_fifo [DEPTH];
    logic [c_CW-1:0] r_count;
    logic [c_CW-1:0] r_outst;
    logic [c_CW-1:0] r_drop;
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;

    logic [c_CW:0]   w_used;
    logic            w_accept;
    logic            w_rsp;
    logic            w_keep;
    logic            w_deq;
    logic [31:0]     w_redirect_pc;

    assign w_used        = {1'b0, r_count} + {1'b0, r_outst};
    assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;

    // Request valid is gated by RESET so nothing is offered while held in reset.
    assign imem_req_valid = RESET && !redirect_valid && (w_used < c_DEPTH);
    assign imem_req_addr  = r_fetch_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding belongs to a request lost across reset.
    assign w_rsp  = imem_rsp_valid && (r_outst != '0);
    assign w_keep = w_rsp && (r_drop == '0) && !redirect_valid;

    assign inst_valid = (r_count != '0) && !redirect_valid;
    assign inst       = (r_count != '0) ? r_fifo[r_rd_ptr] : 32'h0;
    assign pc_plus4   = r_head_pc + 32'd4;
    assign w_deq      = inst_valid && inst_ready;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_fetch_pc <= RESET_PC;
            r_head_pc  <= RESET_PC;
            r_count    <= '0;
            r_outst    <= '0;
            r_drop     <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_outst <= r_outst + c_CW'(w_accept) - c_CW'(w_rsp);
            if (redirect_valid) begin
                r_fetch_pc <= w_redirect_pc;
                r_head_pc  <= w_redirect_pc;
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_drop     <= r_outst - c_CW'(w_rsp);
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_rsp && (r_drop != '0)) begin
                    r_drop <= r_drop - 1'b1;
                end
                if (w_keep) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_deq) begin
                    r_rd_ptr  <= r_rd_ptr + 1'b1;
                    r_head_pc <= r_head_pc + 32'd4;
                end
                r_count <= r_count + c_CW'(w_keep) - c_CW'(w_deq);
            end
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge CLOCK) begin
        if (w_keep) begin
            r_fifo[r_wr_ptr] <= imem_rsp_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_queue
// Description : Randomised self-checking bench for inst_fetch_queue against a
//               queue-based model of the fetch stream and instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] pc_plus4;

    inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .CLOCK          (CLOCK),
        .RESET          (RESET),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .pc_plus4       (pc_plus4)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        bit          orphan;
        int          due;
    } mreq_t;

    mreq_t       memq[$];
    logic [31:0] ready_q[$];
    int          epoch   = 0;
    int          cyc     = 0;
    int          lastdue = 0;
    int          lat     = 1;
    int          dut_acc = 0;
    logic [31:0] exp_head  = RESET_PC;
    logic [31:0] exp_fetch = RESET_PC;
    int          n_assert = 0;
    int          n_fail   = 0;

    function automatic logic [31:0] f_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int inflight();
        int n = 0;
        foreach (memq[i]) if (!memq[i].orphan) n++;
        return n;
    endfunction

    // Entered at posedge+1; returns at the next posedge+1.
    task automatic cycle(input bit rdr, input logic [31:0] tgt, input bit rq_rdy, input bit in_rdy);
        bit          rsp;
        bit          e_rv;
        bit          e_iv;
        logic [31:0] e_inst;
        mreq_t       popped;
        mreq_t       nr;
        redirect_valid = rdr;
        redirect_pc    = tgt;
        imem_req_ready = rq_rdy;
        inst_ready     = in_rdy;
        rsp            = (memq.size() > 0) && (memq[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? f_word(memq[0].addr) : $urandom;
        @(negedge CLOCK);
        if (!RESET) begin
            e_rv = 1'b0;
            e_iv = 1'b0;
            chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
            chk("rst_inst_valid", 32'(inst_valid), 32'd0);
            chk("rst_inst", inst, 32'h0);
            chk("rst_pc_plus4", pc_plus4, RESET_PC + 32'd4);
        end else begin
            e_rv   = !rdr && ((ready_q.size() + inflight()) < DEPTH);
            e_iv   = (ready_q.size() != 0) && !rdr;
            e_inst = (ready_q.size() != 0) ? f_word(ready_q[0]) : 32'h0;
            chk("req_valid", 32'(imem_req_valid), 32'(e_rv));
            if (e_rv) chk("req_addr", imem_req_addr, exp_fetch);
            chk("inst_valid", 32'(inst_valid), 32'(e_iv));
            chk("inst", inst, e_inst);
            chk("pc_plus4", pc_plus4, exp_head + 32'd4);
            if (imem_req_valid && rq_rdy) dut_acc++;
        end
        @(posedge CLOCK);
        if (rsp) popped = memq.pop_front();
        if (RESET) begin
            if (rdr) begin
                epoch++;
                ready_q.delete();
                exp_head  = tgt & 32'hFFFF_FFFC;
                exp_fetch = tgt & 32'hFFFF_FFFC;
            end else begin
                if (e_iv && in_rdy) begin
                    void'(ready_q.pop_front());
                    exp_head += 32'd4;
                end
                if (rsp && !popped.orphan && popped.epoch == epoch) ready_q.push_back(popped.addr);
                if (e_rv && rq_rdy) begin
                    nr.addr   = exp_fetch;
                    nr.epoch  = epoch;
                    nr.orphan = 1'b0;
                    nr.due    = (cyc + lat <= lastdue) ? lastdue + 1 : cyc + lat;
                    lastdue   = nr.due;
                    memq.push_back(nr);
                    exp_fetch += 32'd4;
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (memq.size() > 0 || ready_q.size() > 0); i++) cycle(0, 0, 0, 1);
        chk("drain_done", 32'(memq.size() + ready_q.size()), 32'd0);
    endtask

    initial begin
        int hit;
        // Reset held, then release: sequential fetch at latency 1
        @(posedge CLOCK); #1;
        repeat (3) cycle(0, 0, 1, 1);
        RESET = 1'b1;
        lat = 1;
        repeat (20) cycle(0, 0, 1, 1);

        // Decode stall: exactly DEPTH accepts, then drain and resume
        drain();
        dut_acc = 0;
        repeat (12) cycle(0, 0, 1, 0);
        chk("stall_accepts", 32'(dut_acc), 32'(DEPTH));
        chk("stall_count", 32'(ready_q.size()), 32'(DEPTH));
        repeat (12) cycle(0, 0, 1, 1);

        // Latency 3 stream, redirect with requests in flight
        lat = 3;
        repeat (10) cycle(0, 0, 1, 1);
        cycle(1, 32'h100, 1, 1);
        repeat (15) cycle(0, 0, 1, 1);

        // Latency 2 stream: redirect coincides with a response and ready decode
        lat = 2;
        repeat (10) cycle(0, 0, 1, 1);
        cycle(1, 32'h0000_2003, 1, 1);
        repeat (10) cycle(0, 0, 1, 1);

        // Randomised traffic with occasional redirects
        for (int i = 0; i < 400; i++) begin
            lat = $urandom_range(1, 5);
            cycle(($urandom_range(0, 15) == 0), $urandom, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) != 0));
        end

        // Memory back-pressure, then wrap-around redirect
        lat = 1;
        repeat (5) cycle(0, 0, 0, 1);
        cycle(1, 32'hFFFF_FFFF, 1, 1);
        repeat (8) cycle(0, 0, 1, 1);

        // Mid-stream async reset with three queued and one outstanding
        drain();
        lat = 2;
        cycle(1, 32'h400, 1, 0);
        hit = 0;
        for (int i = 0; i < 20 && hit == 0; i++) begin
            if (ready_q.size() == 3 && inflight() == 1) hit = 1;
            else cycle(0, 0, 1, 0);
        end
        chk("reset_point_reached", 32'(hit), 32'd1);
        #2;
        RESET = 1'b0;
        #1;
        chk("async_req_valid", 32'(imem_req_valid), 32'd0);
        chk("async_inst_valid", 32'(inst_valid), 32'd0);
        chk("async_inst", inst, 32'h0);
        chk("async_pc_plus4", pc_plus4, RESET_PC + 32'd4);
        foreach (memq[i]) memq[i].orphan = 1'b1;
        ready_q.delete();
        epoch++;
        exp_head  = RESET_PC;
        exp_fetch = RESET_PC;
        @(posedge CLOCK); #1;
        cycle(0, 0, 0, 1);
        RESET = 1'b1;
        for (int i = 0; i < 20 && memq.size() > 0; i++) cycle(0, 0, 0, 1);
        chk("late_rsp_seen", 32'(memq.size()), 32'd0);
        repeat (15) cycle(0, 0, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
